// File: rtl/rst_seq.sv
// rtl/rst_seq.sv - reset sequencer and soft-reset request arbiter; optional watchdog under RST_WDT_EN
module rst_seq #(
  parameter int N_REQ   = 4,
  parameter int N_STAGE = 3,
  parameter int HOLD    = 16,
  parameter int GAP     = 4,
  parameter int CNT_W   = 8,
  parameter int WDT_W   = 20
) (
  input  logic               clk,
  input  logic               sys_rstn,
  input  logic [N_REQ-1:0]   req,
  output logic [N_REQ-1:0]   ack,
  input  logic               wdt_kick,
  output logic [N_STAGE-1:0] stage_rstn,
  output logic               busy,
  output logic [N_REQ:0]     cause,
  output logic [CNT_W-1:0]   rst_count
);

  localparam logic [1:0] S_ASSERT  = 2'd0;
  localparam logic [1:0] S_RELEASE = 2'd1;
  localparam logic [1:0] S_IDLE    = 2'd2;

  localparam int TW    = $clog2(HOLD + GAP + 1);
  localparam int IDX_W = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;

  logic [1:0]         state_q, state_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N_STAGE-1:0] stage_q, stage_d;
  logic               busy_q, busy_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [N_REQ:0]     cause_q, cause_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               wdt_req;
  logic [N_REQ:0]     ev_req;

  // Requests from all sources merged into one vector; bit N_REQ is the watchdog
  assign ev_req = {wdt_req, req};

`ifdef RST_WDT_EN
  logic [WDT_W-1:0] wdt_q, wdt_d;

  assign wdt_req = &wdt_q;

  // Watchdog counts IDLE cycles only; cleared by kick, by any accepted event and while sequencing
  always_comb begin
    wdt_d = wdt_q;
    if (state_q != S_IDLE) begin
      wdt_d = '0;
    end else if (|ev_req) begin
      wdt_d = '0;
    end else if (wdt_kick) begin
      wdt_d = '0;
    end else begin
      wdt_d = wdt_q + 1'b1;
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`else
  logic [WDT_W-1:0] unused_wdt_cnt;

  assign wdt_req        = 1'b0;
  assign unused_wdt_cnt = {WDT_W{wdt_kick}};
`endif

  // Sequencer FSM: hold all stages, release them one by one, then arbitrate new requests.
  // The acceptance edge counts as the first hold cycle, so the timer restarts at 1 there
  // to give soft events the same release timing as power-on.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    busy_d  = busy_q;
    ack_d   = '0;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_ASSERT: begin
        if (tmr_q == TW'(HOLD - 1)) begin
          state_d = S_RELEASE;
          tmr_d   = TW'(GAP - 1);
          idx_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (tmr_q == TW'(GAP - 1)) begin
          for (int k = 0; k < N_STAGE; k++) begin
            if (idx_q == IDX_W'(k)) begin
              stage_d[k] = 1'b1;
            end
          end
          tmr_d = '0;
          if (idx_q == IDX_W'(N_STAGE - 1)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (|ev_req) begin
          ack_d   = req;
          cause_d = ev_req;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
          stage_d = '0;
          busy_d  = 1'b1;
          idx_d   = '0;
          if (HOLD == 1) begin
            state_d = S_RELEASE;
            tmr_d   = TW'(GAP - 1);
          end else begin
            state_d = S_ASSERT;
            tmr_d   = TW'(1);
          end
        end
      end
      default: begin
        state_d = S_ASSERT;
        tmr_d   = '0;
        idx_d   = '0;
        stage_d = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  // State and output registers; sys_rstn forces the full hold state immediately
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q <= S_ASSERT;
      tmr_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      busy_q  <= 1'b1;
      ack_q   <= '0;
      cause_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stage_rstn = stage_q;
  assign busy       = busy_q;
  assign ack        = ack_q;
  assign cause      = cause_q;
  assign rst_count  = cnt_q;

endmodule

// File: tb/tb_rst_seq.sv
// tb/tb_rst_seq.sv - directed self-checking bench for rst_seq
module tb_rst_seq;

  logic       clk;
  logic       sys_rstn;
  logic [3:0] req;
  logic [3:0] ack;
  logic       wdt_kick;
  logic [2:0] stage_rstn;
  logic       busy;
  logic [4:0] cause;
  logic [7:0] rst_count;

  int errors;
  int checks;

  rst_seq #(
    .N_REQ  (4),
    .N_STAGE(3),
    .HOLD   (16),
    .GAP    (4),
    .CNT_W  (8),
    .WDT_W  (4)
  ) dut (
    .clk       (clk),
    .sys_rstn  (sys_rstn),
    .req       (req),
    .ack       (ack),
    .wdt_kick  (wdt_kick),
    .stage_rstn(stage_rstn),
    .busy      (busy),
    .cause     (cause),
    .rst_count (rst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed release edges: stage 0 at 17, stage 1 at 21, stage 2 at 25
  function automatic logic [2:0] exp_stage(input int e);
    logic [2:0] s;
    s[0] = (e >= 17);
    s[1] = (e >= 21);
    s[2] = (e >= 25);
    return s;
  endfunction

  task automatic wait_ack(input string name, output int ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ack != 4'b0) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (ok == 0) begin
      errors++;
      $display("FAIL %s: no ack within 40 cycles, ack=%b required nonzero", name, ack);
    end
  endtask

  task automatic wait_idle(input string name);
    int ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (!busy) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (ok == 0) begin
      errors++;
      $display("FAIL %s: busy still high after 60 cycles, busy=%b required 0", name, busy);
    end
  endtask

  task automatic test_reset;
    sys_rstn = 1'b0;
    req      = 4'b0;
    wdt_kick = 1'b0;
    #12;
    checks += 5;
    if (stage_rstn !== 3'b000) begin errors++; $display("FAIL reset_stage: got %b required 000", stage_rstn); end
    if (busy !== 1'b1)         begin errors++; $display("FAIL reset_busy: got %b required 1", busy); end
    if (ack !== 4'b0)          begin errors++; $display("FAIL reset_ack: got %b required 0000", ack); end
    if (cause !== 5'b0)        begin errors++; $display("FAIL reset_cause: got %b required 00000", cause); end
    if (rst_count !== 8'd0)    begin errors++; $display("FAIL reset_count: got %0d required 0", rst_count); end
  endtask

  task automatic test_power_on;
    @(negedge clk);
    sys_rstn = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      @(posedge clk); #1;
      checks += 2;
      if (stage_rstn !== exp_stage(e)) begin
        errors++; $display("FAIL por_stage edge %0d: got %b required %b", e, stage_rstn, exp_stage(e));
      end
      if (busy !== (e < 25)) begin
        errors++; $display("FAIL por_busy edge %0d: got %b required %b", e, busy, (e < 25));
      end
    end
    checks += 2;
    if (cause !== 5'b0)     begin errors++; $display("FAIL por_cause: got %b required 00000", cause); end
    if (rst_count !== 8'd0) begin errors++; $display("FAIL por_count: got %0d required 0", rst_count); end
  endtask

  task automatic soft_event(input string name, input logic [3:0] r, input logic [4:0] exp_cause,
                            input logic [7:0] exp_cnt);
    int ok;
    req = r;
    wait_ack(name, ok);
    req = 4'b0;
    if (ok != 0) begin
      checks += 5;
      if (ack !== r)             begin errors++; $display("FAIL %s_ack: got %b required %b", name, ack, r); end
      if (stage_rstn !== 3'b000) begin errors++; $display("FAIL %s_stage0: got %b required 000", name, stage_rstn); end
      if (busy !== 1'b1)         begin errors++; $display("FAIL %s_busy: got %b required 1", name, busy); end
      if (cause !== exp_cause)   begin errors++; $display("FAIL %s_cause: got %b required %b", name, cause, exp_cause); end
      if (rst_count !== exp_cnt) begin errors++; $display("FAIL %s_count: got %0d required %0d", name, rst_count, exp_cnt); end
      for (int e = 2; e <= 25; e++) begin
        @(posedge clk); #1;
        checks += 3;
        if (stage_rstn !== exp_stage(e)) begin
          errors++; $display("FAIL %s_stage edge %0d: got %b required %b", name, e, stage_rstn, exp_stage(e));
        end
        if (busy !== (e < 25)) begin
          errors++; $display("FAIL %s_busyseq edge %0d: got %b required %b", name, e, busy, (e < 25));
        end
        if (ack !== 4'b0) begin
          errors++; $display("FAIL %s_ackpulse edge %0d: got %b required 0000", name, e, ack);
        end
      end
    end
  endtask

  task automatic test_single_req;
    soft_event("single", 4'b0100, 5'b00100, 8'd1);
  endtask

  task automatic test_merge;
    soft_event("merge", 4'b1001, 5'b01001, 8'd2);
  endtask

  task automatic test_busy_req;
    int ok;
    req = 4'b0001;
    wait_ack("busyreq_first", ok);
    req = 4'b0;
    if (ok != 0) begin
      for (int e = 2; e <= 26; e++) begin
        @(posedge clk); #1;
        checks++;
        if (ack !== ((e == 26) ? 4'b0010 : 4'b0000)) begin
          errors++; $display("FAIL busyreq_ack edge %0d: got %b required %b", e, ack,
                             ((e == 26) ? 4'b0010 : 4'b0000));
        end
        if (e == 5) req = 4'b0010;
        if (e == 26) begin
          req = 4'b0;
          checks += 3;
          if (cause !== 5'b00010)   begin errors++; $display("FAIL busyreq_cause: got %b required 00010", cause); end
          if (rst_count !== 8'd4)   begin errors++; $display("FAIL busyreq_count: got %0d required 4", rst_count); end
          if (stage_rstn !== 3'b0)  begin errors++; $display("FAIL busyreq_stage: got %b required 000", stage_rstn); end
        end
      end
    end
    wait_idle("busyreq_idle");
  endtask

  task automatic test_async_reset;
    int ok;
    req = 4'b0001;
    wait_ack("async_ack", ok);
    req = 4'b0;
    for (int e = 2; e <= 18; e++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (stage_rstn !== 3'b001) begin errors++; $display("FAIL async_pre_stage: got %b required 001", stage_rstn); end
    #3;
    sys_rstn = 1'b0;
    #1;
    checks += 4;
    if (stage_rstn !== 3'b000) begin errors++; $display("FAIL async_stage: got %b required 000", stage_rstn); end
    if (busy !== 1'b1)         begin errors++; $display("FAIL async_busy: got %b required 1", busy); end
    if (rst_count !== 8'd0)    begin errors++; $display("FAIL async_count: got %0d required 0", rst_count); end
    if (cause !== 5'b0)        begin errors++; $display("FAIL async_cause: got %b required 00000", cause); end
    repeat (3) @(posedge clk);
    test_power_on();
  endtask

`ifdef RST_WDT_EN
  task automatic test_wdt;
    for (int e = 26; e <= 41; e++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== (e == 41)) begin
        errors++; $display("FAIL wdt_fire edge %0d: busy got %b required %b", e, busy, (e == 41));
      end
    end
    checks += 3;
    if (cause !== 5'b10000)  begin errors++; $display("FAIL wdt_cause: got %b required 10000", cause); end
    if (rst_count !== 8'd1)  begin errors++; $display("FAIL wdt_count: got %0d required 1", rst_count); end
    if (ack !== 4'b0)        begin errors++; $display("FAIL wdt_ack: got %b required 0000", ack); end
    wait_idle("wdt_idle");
    for (int i = 0; i < 200; i++) begin
      wdt_kick = (i % 10 == 0);
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL wdt_kicked cycle %0d: busy got %b required 0", i, busy);
      end
    end
    wdt_kick = 1'b0;
  endtask
`else
  task automatic test_wdt;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL nowdt_idle cycle %0d: busy got %b required 0", i, busy);
      end
    end
    checks++;
    if (cause !== 5'b0) begin errors++; $display("FAIL nowdt_cause: got %b required 00000", cause); end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_power_on();
    test_single_req();
    test_merge();
    test_busy_req();
    test_async_reset();
    test_wdt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
